// File: rtl/imem_fetch_unit.sv
// Instruction-fetch sequencer: owns the fetch PC, reads a combinational instruction
// memory, and buffers fetched words in a small FIFO ahead of decode.
module imem_fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 1025,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic push, pop, full, flush, load_pc, set_fault, clr_fault;
  logic pc_oob, redirect_bad;

  assign pc_oob       = ({2'b00, fetch_pc[31:2]} >= 32'(MEM_WORDS));
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) ||
                        ({2'b00, redirect_pc[31:2]} >= 32'(MEM_WORDS));

  assign full      = (count == (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign imem_addr = {2'b00, fetch_pc[31:2]};
  assign busy      = (state == RUN);
  assign out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    flush      = 1'b0;
    load_pc    = 1'b0;
    set_fault  = 1'b0;
    clr_fault  = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) load_pc = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_bad) begin
            set_fault  = 1'b1;
            state_next = FAULT;
          end else begin
            load_pc = 1'b1;
          end
        end else if (pc_oob) begin
          set_fault  = 1'b1;
          state_next = FAULT;
        end else if (!full) begin
          push = 1'b1;
        end
      end
      FAULT: begin
        // Queue keeps draining here; only a good redirect restarts fetching.
        if (redirect_valid) begin
          if (redirect_bad) begin
            set_fault = 1'b1;
          end else begin
            clr_fault  = 1'b1;
            flush      = 1'b1;
            load_pc    = 1'b1;
            state_next = RUN;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fault    <= 1'b0;
      fault_pc <= 32'h0;
    end else begin
      if (load_pc)   fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      if (set_fault) begin
        fault    <= 1'b1;
        fault_pc <= redirect_valid ? redirect_pc : fetch_pc;
      end else if (clr_fault) begin
        fault <= 1'b0;
      end

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  // NOTE: queue storage is left unreset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_data;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed stimulus pushes expected {pc, instr}
// pairs; per-DUT monitors pop and compare on every accepted handshake.
module tb_imem_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1024];

  // Main DUT, default MEM_WORDS
  logic        start = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_data, out_instr, out_pc, fault_pc;
  logic        out_valid, busy, fault;

  // Small DUT, MEM_WORDS = 4
  logic        start4 = 0, redirect_valid4 = 0, out_ready4 = 0;
  logic [31:0] redirect_pc4 = 0, imem_addr4, imem_data4, out_instr4, out_pc4, fault_pc4;
  logic        out_valid4, busy4, fault4;

  always_comb imem_data  = (imem_addr  < 32'd1025) ? mem[imem_addr[10:0]]  : 32'hDEAD_BEEF;
  always_comb imem_data4 = (imem_addr4 < 32'd1025) ? mem[imem_addr4[10:0]] : 32'hDEAD_BEEF;

  imem_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy), .fault(fault), .fault_pc(fault_pc)
  );

  imem_fetch_unit #(.DEPTH(2), .MEM_WORDS(4), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .imem_addr(imem_addr4), .imem_data(imem_data4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_instr(out_instr4), .out_pc(out_pc4),
    .busy(busy4), .fault(fault4), .fault_pc(fault_pc4)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t exp4_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_main(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: mem[pc[12:2]]});
  endtask

  task automatic expect_small(input logic [31:0] pc);
    exp4_q.push_back('{pc: pc, instr: mem[pc[12:2]]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Monitors: compare every accepted head against the scoreboard
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL main_unexpected_pop: got pc 0x%08h expected no transfer", out_pc);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        check("main_stream_pc", out_pc, e.pc);
        check("main_stream_instr", out_instr, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        $display("FAIL small_unexpected_pop: got pc 0x%08h expected no transfer", out_pc4);
      end else begin
        automatic exp_t e = exp4_q.pop_front();
        check("small_stream_pc", out_pc4, e.pc);
        check("small_stream_instr", out_instr4, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1025; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;

    // Reset state
    #12 rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);

    // Streaming with out_ready high: first valid two cycles after start
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_main(32'(i * 4));
    pulse_start();
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_no_valid_yet", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("start_valid_n2", 32'(out_valid), 32'd1);
    repeat (4) tick();
    out_ready = 1'b0;

    // Backpressure: queue fills to DEPTH, head stable, then drains without gaps
    apply_reset();
    tick();
    pulse_start();
    repeat (4) tick();
    @(negedge clk);
    check("stall_imem_addr", imem_addr, 32'd2);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_head_pc", out_pc, 32'h0);
    check("stall_head_instr", out_instr, 32'h2008_0001);
    tick();
    expect_main(32'h0); expect_main(32'h4); expect_main(32'h8);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;

    // Redirect flush while queue holds PCs 8 and 12
    apply_reset();
    tick();
    out_ready = 1'b1;
    expect_main(32'h0); expect_main(32'h4);
    pulse_start();
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    check("pre_redirect_head", out_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redirect_head_pc", out_pc, 32'h40);
    check("redirect_head_instr", out_instr, mem[16]);
    tick();
    expect_main(32'h40); expect_main(32'h44);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;

    // Misaligned redirect faults, aligned redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("bad_redirect_fault", 32'(fault), 32'd1);
    check("bad_redirect_fault_pc", fault_pc, 32'h42);
    check("bad_redirect_busy", 32'(busy), 32'd0);
    check("bad_redirect_flush", 32'(out_valid), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("fault_no_push", 32'(out_valid), 32'd0);
    check("fault_pc_frozen", imem_addr, 32'd19);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("recover_fault_clear", 32'(fault), 32'd0);
    check("recover_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("recover_head_pc", out_pc, 32'h10);
    check("recover_head_instr", out_instr, mem[4]);

    // Out-of-range fetch on MEM_WORDS=4 instance; queued words still drain
    apply_reset();
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("small_full_valid", 32'(out_valid4), 32'd1);
    check("small_stall_addr", imem_addr4, 32'd2);
    check("small_no_fault_yet", 32'(fault4), 32'd0);
    tick();
    expect_small(32'h0); expect_small(32'h4); expect_small(32'h8); expect_small(32'hC);
    out_ready4 = 1'b1;
    repeat (2) tick();
    out_ready4 = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("oob_fault", 32'(fault4), 32'd1);
    check("oob_fault_pc", fault_pc4, 32'h10);
    check("oob_busy", 32'(busy4), 32'd0);
    check("oob_queue_kept", 32'(out_valid4), 32'd1);
    check("oob_queue_head", out_pc4, 32'h8);
    tick();
    out_ready4 = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("oob_drained", 32'(out_valid4), 32'd0);
    out_ready4 = 1'b0;

    // Asynchronous reset mid-stream
    tick();
    pulse_start();
    repeat (2) tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_fault4", 32'(fault4), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_fault4", 32'(fault4), 32'd0);
    check("async_rst_out_pc", out_pc, 32'h0);
    #3 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    check("main_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("small_scoreboard_empty", 32'(exp4_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
